// File: rtl/rice_split_encoder_if.sv
// Handshake and data bundle between a Rice encoder and the logic that feeds
// and drains it. Signal suffixes are from the encoder's point of view.
interface rice_split_encoder_if #(
  parameter int SAMPLE_W = 16
);
  logic                start_i;
  logic                stop_i;
  logic [5:0]          k_i;
  logic [5:0]          j_i;
  logic [SAMPLE_W-1:0] sdata_i;
  logic                svalid_i;
  logic                sready_o;
  logic [31:0]         opdata_o;
  logic                ovalid_o;
  logic                oready_i;
  logic                busy_o;
  logic                done_o;

  // Stimulus / sink side
  modport master (
    output start_i, stop_i, k_i, j_i, sdata_i, svalid_i, oready_i,
    input  sready_o, opdata_o, ovalid_o, busy_o, done_o
  );

  // Encoder side
  modport slave (
    input  start_i, stop_i, k_i, j_i, sdata_i, svalid_i, oready_i,
    output sready_o, opdata_o, ovalid_o, busy_o, done_o
  );
endinterface

// File: rtl/rice_split_encoder.sv
// Rice split-sample encoder. Buffers a block of j samples, emits every
// sample's fundamental-sequence code, then the k low bits of every sample,
// one bit per cycle, into a continuous MSB-first stream of 32-bit words.
module rice_split_encoder #(
  parameter int SAMPLE_W = 16,
  parameter int J_MAX    = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  rice_split_encoder_if.slave  bus
);

  localparam int KW = $clog2(SAMPLE_W + 1);  // holds k = 0..SAMPLE_W
  localparam int BW = $clog2(SAMPLE_W);      // bit position inside a sample
  localparam int JW = $clog2(J_MAX + 1);     // holds j = 0..J_MAX
  localparam int IW = $clog2(J_MAX);         // sample buffer index

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FS,
    S_KS,
    S_FLUSH
  } state_e;

  state_e              state_q;
  logic [KW-1:0]       k_q;
  logic [JW-1:0]       j_q;
  logic [IW-1:0]       idx_q;
  logic [SAMPLE_W-1:0] run_q;      // zeros already sent for the current FS code
  logic [BW-1:0]       bit_q;      // next LSB position to send in KS
  logic [31:0]         sr_q;       // packer shift register
  logic [4:0]          cnt_q;      // bits held in sr_q for the open word
  logic [31:0]         opdata_q;
  logic                ovalid_q;
  logic                sready_q;
  logic                busy_q;
  logic                done_q;
  logic                stop_q;

  logic [SAMPLE_W-1:0] buf_q [J_MAX];

  logic                can_emit;
  logic                emit_en;
  logic                emit_bit;
  logic                last_idx;
  logic                blk_end;
  logic [SAMPLE_W-1:0] cur;
  logic [SAMPLE_W-1:0] q_val;
  logic [KW-1:0]       k_clamp;
  logic [JW-1:0]       j_clamp;

  assign k_clamp = (bus.k_i > 6'(SAMPLE_W)) ? KW'(SAMPLE_W) : KW'(bus.k_i);
  assign j_clamp = (bus.j_i > 6'(J_MAX))    ? JW'(J_MAX)    : JW'(bus.j_i);

  // Current code bit, whether it may leave this cycle, and end-of-block detect
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    can_emit = !ovalid_q || bus.oready_i;
    cur      = buf_q[idx_q];
    q_val    = cur >> k_q;
    last_idx = (JW'(idx_q) == j_q - JW'(1));
    emit_en  = 1'b0;
    emit_bit = 1'b0;
    blk_end  = 1'b0;
    case (state_q)
      S_FS: begin
        emit_en  = can_emit;
        emit_bit = (run_q == q_val);
        blk_end  = can_emit && emit_bit && last_idx && (k_q == '0);
      end
      S_KS: begin
        emit_en  = can_emit;
        emit_bit = cur[bit_q];
        blk_end  = can_emit && (bit_q == '0) && last_idx;
      end
      default: ;
    endcase
  end

  // Sample buffer write during LOAD
  // NOTE: the buffer has no reset; its contents are always written before being read.
  always_ff @(posedge clk_i) begin
    if (state_q == S_LOAD && bus.svalid_i && sready_q) buf_q[idx_q] <= bus.sdata_i;
  end

  // Control FSM, bit packer and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: non-blocking assignments throughout; later ones in the block take priority.
    if (reset_i) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      j_q      <= '0;
      idx_q    <= '0;
      run_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      opdata_q <= '0;
      ovalid_q <= 1'b0;
      sready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop_i)   stop_q   <= 1'b1;
      if (bus.oready_i) ovalid_q <= 1'b0;

      // Packer: the 32nd bit completes a word; the count wraps back to zero.
      if (emit_en) begin
        sr_q  <= {sr_q[30:0], emit_bit};
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          opdata_q <= {sr_q[30:0], emit_bit};
          ovalid_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            k_q   <= k_clamp;
            j_q   <= j_clamp;
            idx_q <= '0;
            if (j_clamp == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= S_LOAD;
              sready_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (bus.svalid_i && sready_q) begin
            if (last_idx) begin
              state_q  <= S_FS;
              sready_q <= 1'b0;
              idx_q    <= '0;
              run_q    <= '0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end

        S_FS: begin
          if (emit_en) begin
            if (emit_bit) begin
              run_q <= '0;
              if (last_idx) begin
                idx_q   <= '0;
                bit_q   <= BW'(k_q - KW'(1));
                state_q <= S_KS;
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end else begin
              run_q <= run_q + SAMPLE_W'(1);
            end
          end
        end

        S_KS: begin
          if (emit_en) begin
            if (bit_q == '0) begin
              bit_q <= BW'(k_q - KW'(1));
              idx_q <= idx_q + IW'(1);
            end else begin
              bit_q <= bit_q - BW'(1);
            end
          end
        end

        S_FLUSH: begin
          if (cnt_q == '0 || can_emit) begin
            if (cnt_q != '0) begin
              opdata_q <= sr_q << (6'd32 - {1'b0, cnt_q});
              ovalid_q <= 1'b1;
              cnt_q    <= '0;
            end
            stop_q  <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase

      // Block end overrides the FS/KS transitions above.
      if (blk_end) begin
        idx_q <= '0;
        if (stop_q || bus.stop_i) begin
          state_q <= S_FLUSH;
        end else begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.sready_o = sready_q;
  assign bus.opdata_o = opdata_q;
  assign bus.ovalid_o = ovalid_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_rice_split_encoder.sv
// Self-checking bench for rice_split_encoder: directed scenarios plus random
// blocks under random backpressure, compared against a bit-queue model.
module tb_rice_split_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rice_split_encoder_if #(.SAMPLE_W(16)) bus ();

  rice_split_encoder #(.SAMPLE_W(16), .J_MAX(16)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int          n_cmp   = 0;
  int          n_err   = 0;
  int          n_extra = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  logic [15:0] smp [16];
  bit          bits_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  // Downstream ready generator
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.oready_i = 1'b1;
      1:       bus.oready_i = ($urandom_range(0, 3) != 0);
      default: bus.oready_i = 1'b0;
    endcase
  end

  // Output monitor: every accepted word is compared to the model stream
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done_o) done_cnt++;
      if (bus.ovalid_o && bus.oready_i) begin
        got_q.push_back(bus.opdata_o);
        if (exp_q.size() > 0) check("stream_word", bus.opdata_o, exp_q.pop_front());
        else n_extra++;
      end
    end
  end

  // Reference: append the block's bits to a continuous stream, cut 32-bit words
  task automatic model_block(input int kk, input int jj, input bit stp);
    logic [31:0] w;
    int n;
    for (int i = 0; i < jj; i++) begin
      n = int'(smp[i] >> kk);
      for (int z = 0; z < n; z++) bits_q.push_back(1'b0);
      bits_q.push_back(1'b1);
    end
    for (int i = 0; i < jj; i++)
      for (int b = kk - 1; b >= 0; b--) bits_q.push_back(smp[i][b]);
    while (bits_q.size() >= 32) begin
      w = '0;
      for (int b = 0; b < 32; b++) w = {w[30:0], bits_q.pop_front()};
      exp_q.push_back(w);
    end
    if (stp && bits_q.size() > 0) begin
      n = bits_q.size();
      w = '0;
      for (int b = 0; b < n; b++) w = {w[30:0], bits_q.pop_front()};
      exp_q.push_back(w << (32 - n));
    end
  endtask

  task automatic drive_block(input int k_raw, input int j_raw, input bit stp, input bit gaps);
    int n;
    bit acc;
    int jj;
    jj = (j_raw > 16) ? 16 : j_raw;
    @(posedge clk);
    #1;
    n = 0;
    while (bus.busy_o && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.k_i     = 6'(k_raw);
    bus.j_i     = 6'(j_raw);
    bus.stop_i  = stp;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    for (int i = 0; i < jj; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      bus.sdata_i  = smp[i];
      bus.svalid_i = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.sready_o && n < 100);
      acc = bus.sready_o;
      @(posedge clk);
      #1;
      bus.svalid_i = 1'b0;
      check("load_accept", 32'(acc), 32'd1);
      if (!acc) finish_run();
    end
  endtask

  task automatic run_block(input int k_raw, input int j_raw, input bit stp, input bit gaps);
    int d0;
    int n;
    model_block((k_raw > 16) ? 16 : k_raw, (j_raw > 16) ? 16 : j_raw, stp);
    d0 = done_cnt;
    drive_block(k_raw, j_raw, stp, gaps);
    n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("block_done", 32'(done_cnt - d0), 32'd1);
    if (done_cnt == d0) finish_run();
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int d0;
    reset        = 1'b1;
    bus.start_i  = 1'b0;
    bus.stop_i   = 1'b0;
    bus.k_i      = '0;
    bus.j_i      = '0;
    bus.sdata_i  = '0;
    bus.svalid_i = 1'b0;
    bus.oready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sready", 32'(bus.sready_o), 32'd0);
    check("rst_ovalid", 32'(bus.ovalid_o), 32'd0);
    check("rst_opdata", bus.opdata_o, 32'h0);
    check("rst_busy",   32'(bus.busy_o), 32'd0);
    check("rst_done",   32'(bus.done_o), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic block
    got_q.delete();
    smp[0] = 16'd5; smp[1] = 16'd2;
    d0 = done_cnt;
    run_block(2, 2, 1'b1, 1'b0);
    settle();
    check("basic_words", 32'(got_q.size()), 32'd1);
    check("basic_word",  got_q[0], 32'h6C00_0000);
    check("basic_done",  32'(done_cnt - d0), 32'd1);
    check("basic_busy",  32'(bus.busy_o), 32'd0);

    // k = 0 skips the split bits
    got_q.delete();
    for (int i = 0; i < 4; i++) smp[i] = 16'd0;
    run_block(0, 4, 1'b1, 1'b1);
    settle();
    check("k0_word", got_q[0], 32'hF000_0000);

    // A 41-bit code crossing a word boundary
    got_q.delete();
    smp[0] = 16'd40;
    run_block(0, 1, 1'b1, 1'b0);
    settle();
    check("cross_words", 32'(got_q.size()), 32'd2);
    check("cross_w0",    got_q[0], 32'h0000_0000);
    check("cross_w1",    got_q[1], 32'h0080_0000);

    // Same stream with the first word held by backpressure
    got_q.delete();
    smp[0] = 16'd40;
    rdy_mode = 2;
    fork
      run_block(0, 1, 1'b1, 1'b0);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.ovalid_o && n < 500);
        check("bp_seen", 32'(bus.ovalid_o), 32'd1);
        repeat (10) begin
          @(negedge clk);
          check("bp_hold",  bus.opdata_o, 32'h0);
          check("bp_valid", 32'(bus.ovalid_o), 32'd1);
          check("bp_busy",  32'(bus.busy_o), 32'd1);
        end
        check("bp_no_second", 32'(got_q.size()), 32'd0);
        rdy_mode = 0;
      end
    join
    settle();
    check("bp_words", 32'(got_q.size()), 32'd2);
    check("bp_w0",    got_q[0], 32'h0000_0000);
    check("bp_w1",    got_q[1], 32'h0080_0000);

    // Stream continuity across two blocks
    got_q.delete();
    smp[0] = 16'd3;
    run_block(1, 1, 1'b0, 1'b0);
    settle();
    check("cont_none", 32'(got_q.size()), 32'd0);
    smp[0] = 16'd2;
    run_block(1, 1, 1'b1, 1'b0);
    settle();
    check("cont_words", 32'(got_q.size()), 32'd1);
    check("cont_word",  got_q[0], 32'h6800_0000);

    // Empty block: done only
    got_q.delete();
    run_block(3, 0, 1'b0, 1'b0);
    settle();
    check("j0_busy",  32'(bus.busy_o), 32'd0);
    check("j0_words", 32'(got_q.size()), 32'd0);

    // Reset in the middle of a long zero run
    got_q.delete();
    smp[0] = 16'd40;
    drive_block(0, 1, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    check("rst_pre_busy", 32'(bus.busy_o), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("amid_ovalid", 32'(bus.ovalid_o), 32'd0);
    check("amid_opdata", bus.opdata_o, 32'h0);
    check("amid_sready", 32'(bus.sready_o), 32'd0);
    check("amid_busy",   32'(bus.busy_o), 32'd0);
    bits_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    smp[0] = 16'd5; smp[1] = 16'd2;
    run_block(2, 2, 1'b1, 1'b0);
    settle();
    check("post_rst_words", 32'(got_q.size()), 32'd1);
    check("post_rst_word",  got_q[0], 32'h6C00_0000);

    // Random blocks under random backpressure
    rdy_mode = 1;
    for (int b = 0; b < 25; b++) begin
      int kr, jr, kk, lim;
      bit st;
      kr  = $urandom_range(0, 20);
      jr  = $urandom_range(1, 20);
      kk  = (kr > 16) ? 16 : kr;
      st  = (b == 24) || ($urandom_range(0, 2) == 0);
      lim = (kk >= 11) ? 65535 : ((32 << kk) - 1);
      for (int i = 0; i < 16; i++) smp[i] = 16'($urandom_range(0, lim));
      run_block(kr, jr, st, 1'b1);
    end
    rdy_mode = 0;
    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    settle();
    check("missing_words", 32'(exp_q.size()), 32'd0);
    check("extra_words",   32'(n_extra), 32'd0);
    check("end_busy",      32'(bus.busy_o), 32'd0);
    finish_run();
  end

endmodule

// File: doc/rice_split_encoder.md
Name: rice_split_encoder

Overview:
- Rice (split-sample) encoder: the transmit-side counterpart of the telemetry Rice decompression path.
- Takes blocks of j mapped residual samples and a split parameter k.
- Emits, for each block, the fundamental-sequence (FS) codes of all j samples first, then the k LSBs of all j samples, packed MSB-first into 32-bit words.
- Generates the test streams that feed the decoder's ipdata/ordata inputs.

Parameters:
- SAMPLE_W, 16, width of one input sample.
- J_MAX, 16, maximum samples per block (sample buffer depth).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a block; sampled only in IDLE.
- stop  input  1  request stream termination; latched any cycle, acted on at block end.
- k  input  6  split bits; sampled with start; values >SAMPLE_W clamp to SAMPLE_W.
- j  input  6  samples per block; sampled with start; values >J_MAX clamp to J_MAX.
- sdata  input  SAMPLE_W  sample value.
- svalid  input  1  sdata valid.
- sready  output  1  encoder accepts sdata.
- opdata  output  32  packed code word, first code bit in bit 31.
- ovalid  output  1  opdata valid.
- oready  input  1  downstream accepts opdata.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a block (and any flush) completes.

Behaviour:
- Reset (async): FSM to IDLE; sready, ovalid, busy, done = 0; opdata = 0; packer count = 0; stop latch cleared; sample buffer contents don't-care.
- FSM states: IDLE, LOAD, FS, KS, FLUSH.
- IDLE:
  - On start, latch k and j, go to LOAD.
  - If latched j==0: pulse done and stay IDLE; no bits emitted.
- LOAD:
  - sready=1.
  - Each svalid&&sready stores sdata at index idx, then idx++.
  - After the j-th sample, sready drops and the next state is FS.
- Bit emission: at most one code bit per cycle, and only when !ovalid || oready. Otherwise the FSM holds and all counters freeze.
- FS state, per sample i (0..j-1): q = sample>>k.
  - Emit q zeros, then one '1', then advance i.
  - After sample j-1's '1': go to KS, or to block end if k==0.
- KS state, per sample i: emit bits sample[k-1] down to sample[0], then advance i.
  - After the last bit of sample j-1: go to block end.
- Packer:
  - 32-bit shift register sr plus 5-bit count.
  - Each emitted bit shifts in at LSB.
  - On the 32nd bit, opdata <= {sr[30:0],bit} and ovalid=1 on the next cycle; count returns to 0.
  - ovalid clears after a cycle with oready=1 unless a new word loads in the same cycle.
  - Partial words persist across blocks: the bitstream is continuous.
- Block end:
  - If the stop latch is set: go to FLUSH.
  - Otherwise: pulse done, return to IDLE.
- FLUSH:
  - If count!=0, wait for !ovalid||oready, then load opdata = partial bits left-aligned, zero-padded, and set ovalid.
  - Count reset, stop latch cleared, done pulsed, go to IDLE.
  - If count==0, done pulses immediately.
- stop asserted together with start in IDLE is latched and applies to that block.
- start outside IDLE is ignored.
- q is computed on the full SAMPLE_W width; the zero-run counter is SAMPLE_W bits wide. The maximum run is 2^SAMPLE_W-1 zeros, with no escape code.
- Reset mid-operation aborts immediately: partial word and buffered samples are discarded.

Test Plan:
- Basic block: j=2, k=2, samples 5 then 2, stop=1.
  - FS bits 0,1,1 then KS bits 01,10.
  - Required: a single word 0x6C000000 with ovalid, done pulses once, busy returns 0.
- k=0: j=4, samples 0,0,0,0, stop=1.
  - Required: KS skipped; word 0xF0000000.
- Word crossing: j=1, k=0, sample 40, stop=1.
  - Required: first word 0x00000000 (32 zeros), then flush word 0x00800000.
- Backpressure: the same 41-bit case with oready=0 for 10 cycles after the first ovalid.
  - Required: opdata holds 0x00000000 stable, FSM counters frozen, no second word until oready=1.
  - Final words are identical to the unstalled case.
- Continuity: two blocks (j=1, k=1, samples 3 then 2), stop only on the second.
  - Required: no word after block 1 (done pulses).
  - Stream 0,1,1 then 0,1,0 gives 011010 padded, i.e. 0x68000000.
- Reset mid-FS: assert reset during the zero run of sample 40.
  - Required: ovalid=0, opdata=0, sready=0, busy=0 asynchronously.
  - A subsequent basic block reproduces 0x6C000000.
